alu_4bit: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_4bit_comb.sv | 72 +++++++
 rtl/alu_4bit.sv | 66 ++++++
 tb/tb_alu_4bit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU: opcode encodings, datapath width and
// a small helper used to form the zero flag.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  // Zero flag helper: 1 when every result bit is clear.
  function automatic logic is_zero(input logic [ALU_W-1:0] value);
    return (value == {ALU_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_4bit_comb.sv
// Purely combinational core of the 4-bit ALU: opcode decode, result and
// carry / zero / overflow generation.
// Ports:
//   a_i, b_i     : operands
//   sel_i        : operation select (see alu_pkg opcodes)
//   result_o     : 4-bit result
//   carry_o      : carry-out, no-borrow, or shifted-out bit
//   zero_o       : 1 when result_o is zero
//   overflow_o   : two's-complement overflow (ADD/SUB only)
module alu_4bit_comb
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [2:0]       sel_i,
  output logic [ALU_W-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             overflow_o
);

  logic [ALU_W:0]   sum_s;
  logic [ALU_W-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;

  // Opcode decode with result, carry and overflow generation.
  always_comb begin
    sum_s   = {(ALU_W+1){1'b0}};
    res_s   = {ALU_W{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (sel_i)
      OP_ADD: begin
        sum_s   = {1'b0, a_i} + {1'b0, b_i};
        res_s   = sum_s[ALU_W-1:0];
        carry_s = sum_s[ALU_W];
        ovf_s   = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (res_s[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_SUB: begin
        // Subtract as A + ~B + 1 so the carry-out reads as "no borrow".
        sum_s   = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
        res_s   = sum_s[ALU_W-1:0];
        carry_s = sum_s[ALU_W];
        ovf_s   = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (res_s[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_AND: res_s = a_i & b_i;
      OP_OR:  res_s = a_i | b_i;
      OP_XOR: res_s = a_i ^ b_i;
      OP_NOT: res_s = ~a_i;
      OP_SHL: begin
        res_s   = {a_i[ALU_W-2:0], 1'b0};
        carry_s = a_i[ALU_W-1];
      end
      OP_SHR: begin
        res_s   = {1'b0, a_i[ALU_W-1:1]};
        carry_s = a_i[0];
      end
      default: begin
        res_s   = {ALU_W{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  assign result_o   = res_s;
  assign carry_o    = carry_s;
  assign zero_o     = is_zero(res_s);
  assign overflow_o = ovf_s;

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU execute stage. Operands and opcode are sampled every
// rising edge; result and flags come straight from flops one cycle later.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, clears all outputs
//   A, B     : operands
//   Sel      : operation select
//   Result   : registered result
//   Carry    : registered carry / no-borrow / shifted-out bit
//   Zero     : registered zero flag
//   Overflow : registered signed overflow flag
module alu_4bit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [2:0]       Sel,
  output logic [ALU_W-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow
);

  logic [ALU_W-1:0] result_d;
  logic             carry_d;
  logic             zero_d;
  logic             overflow_d;

  logic [ALU_W-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             overflow_q;

  alu_4bit_comb u_comb (
    .a_i        (A),
    .b_i        (B),
    .sel_i      (Sel),
    .result_o   (result_d),
    .carry_o    (carry_d),
    .zero_o     (zero_d),
    .overflow_o (overflow_d)
  );

  // Output register; reset wins over the operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= {ALU_W{1'b0}};
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result   = result_q;
  assign Carry    = carry_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed cases plus 1000 random cycles
// compared against an integer-arithmetic reference model.
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Sel;
  logic [3:0] Result;
  logic       Carry;
  logic       Zero;
  logic       Overflow;

  int n_checks;
  int n_errors;

  alu_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .Result   (Result),
    .Carry    (Carry),
    .Zero     (Zero),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the arithmetic definitions; returns {R, C, Z, V}.
  function automatic logic [6:0] model(input int a, input int b, input int sel);
    int r;
    int c;
    int v;
    int sa;
    int sb;
    int t;
    r  = 0;
    c  = 0;
    v  = 0;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (sel)
      0: begin
        t = a + b;
        r = t % 16;
        c = (t > 15) ? 1 : 0;
        t = sa + sb;
        v = (t > 7 || t < -8) ? 1 : 0;
      end
      1: begin
        r = (a - b + 16) % 16;
        c = (a >= b) ? 1 : 0;
        t = sa - sb;
        v = (t > 7 || t < -8) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (a * 2) % 16; c = a / 8; end
      7: begin r = a / 2; c = a % 2; end
      default: r = 0;
    endcase
    return {4'(r), 1'(c), (r == 0) ? 1'b1 : 1'b0, 1'(v)};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got R=%b C=%b Z=%b V=%b, expected R=%b C=%b Z=%b V=%b",
               tag, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Present one operation, clock it in, and compare outputs against a given value.
  task automatic op_exp(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel, input logic [6:0] exp);
    A = a; B = b; Sel = sel;
    @(posedge clk); #1;
    check(tag, {Result, Carry, Zero, Overflow}, exp);
  endtask

  // Present one operation and compare outputs against the reference model.
  task automatic op_mdl(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel);
    op_exp(tag, a, b, sel, model(int'(a), int'(b), int'(sel)));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    A = 4'b1111; B = 4'b0001; Sel = 3'd0;

    // Reset with a live operation present: it must be discarded.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", {Result, Carry, Zero, Overflow}, 7'b0000_000);
    rst_n = 1'b1;

    // Directed cases with hand-derived expectations {R,C,Z,V}.
    op_exp("add_ovf",  4'b0101, 4'b0011, 3'd0, 7'b1000_001);
    op_exp("sub_ovf",  4'b1000, 4'b0010, 3'd1, 7'b0110_101);
    op_exp("sub_eq",   4'b0101, 4'b0101, 3'd1, 7'b0000_110);
    op_exp("and",      4'b1100, 4'b1010, 3'd2, 7'b1000_000);
    op_exp("or",       4'b1100, 4'b1010, 3'd3, 7'b1110_000);
    op_exp("xor",      4'b1100, 4'b1010, 3'd4, 7'b0110_000);
    op_exp("and_zero", 4'b1100, 4'b0011, 3'd2, 7'b0000_010);
    op_exp("shl",      4'b1001, 4'b0110, 3'd6, 7'b0010_100);
    op_exp("shr",      4'b1001, 4'b0110, 3'd7, 7'b0100_100);
    op_exp("not",      4'b1001, 4'b1111, 3'd5, 7'b0110_000);
    op_exp("add_wrap", 4'b1111, 4'b0001, 3'd0, 7'b0000_110);
    op_exp("sub_borrow", 4'b0010, 4'b0011, 3'd1, 7'b1111_000);

    // Mid-stream reset: outputs clear on that edge despite a valid operation.
    rst_n = 1'b0;
    op_exp("mid_reset", 4'b0111, 4'b0001, 3'd0, 7'b0000_000);
    rst_n = 1'b1;
    op_exp("resume", 4'b0111, 4'b0001, 3'd0, 7'b1000_001);

    // Inputs that change between edges must not leak into outputs.
    A = 4'b0011; B = 4'b0011; Sel = 3'd1;
    #3;
    op_mdl("glitch_free", 4'b0110, 4'b0001, 3'd0);

    // Back-to-back random operations.
    for (int i = 0; i < 1000; i++) begin
      op_mdl("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
